// File: rtl/traffic_pkg.sv
// traffic_pkg: junction state encoding, timing-register selects and power-up durations
package traffic_pkg;
    typedef enum logic [2:0] {ALL_RED, GREEN, GREEN_EXT, YELLOW, WALK} state_e;
    localparam logic [1:0] SEL_BASE = 2'd0;
    localparam logic [1:0] SEL_EXT  = 2'd1;
    localparam logic [1:0] SEL_YEL  = 2'd2;
    localparam logic [1:0] SEL_WALK = 2'd3;
    localparam int DEF_BASE = 6;
    localparam int DEF_EXT  = 3;
    localparam int DEF_YEL  = 2;
    localparam int DEF_WALK = 3;
endpackage

// File: rtl/tc_second_timer.sv
// tc_second_timer: one-second prescaler feeding a loadable seconds down-counter
module tc_second_timer #(
    parameter int CLK_DIV = 100000000,
    parameter int TIME_W  = 4,
    parameter int INIT_S  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [TIME_W-1:0] load_value_i,
    output logic              tick_o,
    output logic              expired_o
);
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
    logic [PW-1:0]     pre_q, pre_d;
    logic [TIME_W-1:0] cnt_q, cnt_d;
    assign tick_o    = pre_q == LAST;
    assign expired_o = cnt_q <= TIME_W'(1);
    // prescaler restarts on load or tick; a zero load is read as one second
    always_comb begin
        pre_d = (load_i || tick_o) ? '0 : pre_q + 1'b1;
        cnt_d = load_i ? ((load_value_i == '0) ? TIME_W'(1) : load_value_i)
              : (tick_o && !expired_o) ? cnt_q - 1'b1 : cnt_q;
    end
    // counter state, reset into the power-up all-red interval
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q <= '0;
            cnt_q <= TIME_W'(INIT_S);
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: round-robin multi-phase junction with extension, walk and all-red
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int TIME_W     = 4,
    parameter int CLK_DIV    = 100000000,
    parameter int ALL_RED_S  = 1,
    parameter int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_PHASES-1:0] sensor_i,
    input  logic                  walk_req_i,
    input  logic                  reprogram_i,
    input  logic [1:0]            prog_sel_i,
    input  logic [TIME_W-1:0]     prog_value_i,
    output logic [NUM_PHASES-1:0] red_o,
    output logic [NUM_PHASES-1:0] yellow_o,
    output logic [NUM_PHASES-1:0] green_o,
    output logic                  walk_o,
    output logic [PH_W-1:0]       active_phase_o
);
    state_e                state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d, nxt;
    logic [PH_W:0]         cand;
    logic                  ext_used_q, ext_used_d, walk_lat_q, walk_lat_d;
    logic [NUM_PHASES-1:0] dem_q, dem_d, sen_m_q, sen_s_q, cur_oh, nxt_oh;
    logic                  wr_m_q, wr_s_q, wr_p_q;
    logic [TIME_W-1:0]     base_q, ext_q, yel_q, walk_t_q, dur;
    logic [NUM_PHASES-1:0] red_q, yellow_q, green_q, red_d, yellow_d, green_d;
    logic                  walk_q, walk_d, tick, expired, done, pending;

    tc_second_timer #(.CLK_DIV(CLK_DIV), .TIME_W(TIME_W), .INIT_S(ALL_RED_S)) u_timer (
        .clk_i        (clk_i),
        .rst_i        (reset_i),
        .load_i       (done),
        .load_value_i (dur),
        .tick_o       (tick),
        .expired_o    (expired)
    );

    assign done    = tick && expired;
    assign pending = (|dem_q) || walk_lat_q;
    assign cur_oh  = (state_q == GREEN || state_q == GREEN_EXT) ? NUM_PHASES'(1) << phase_q : '0;
    assign nxt_oh  = NUM_PHASES'(1) << phase_d;

    // two-flop synchronisers for the asynchronous sensor and button inputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sen_m_q <= '0;
            sen_s_q <= '0;
            wr_m_q  <= 1'b0;
            wr_s_q  <= 1'b0;
            wr_p_q  <= 1'b0;
        end else begin
            sen_m_q <= sensor_i;
            sen_s_q <= sen_m_q;
            wr_m_q  <= walk_req_i;
            wr_s_q  <= wr_m_q;
            wr_p_q  <= wr_s_q;
        end
    end

    // runtime timing registers; a write only affects the next load of that duration
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            base_q   <= TIME_W'(DEF_BASE);
            ext_q    <= TIME_W'(DEF_EXT);
            yel_q    <= TIME_W'(DEF_YEL);
            walk_t_q <= TIME_W'(DEF_WALK);
        end else begin
            base_q   <= (reprogram_i && prog_sel_i == SEL_BASE) ? prog_value_i : base_q;
            ext_q    <= (reprogram_i && prog_sel_i == SEL_EXT)  ? prog_value_i : ext_q;
            yel_q    <= (reprogram_i && prog_sel_i == SEL_YEL)  ? prog_value_i : yel_q;
            walk_t_q <= (reprogram_i && prog_sel_i == SEL_WALK) ? prog_value_i : walk_t_q;
        end
    end

    // next phase: first demanded approach after the active one, main road always qualifies
    always_comb begin
        cand = '0;
        nxt  = '0;
        for (int k = NUM_PHASES; k >= 1; k--) begin
            cand = {1'b0, phase_q} + (PH_W+1)'(k);
            cand = (cand >= (PH_W+1)'(NUM_PHASES)) ? cand - (PH_W+1)'(NUM_PHASES) : cand;
            if (cand == '0 || dem_q[cand[PH_W-1:0]])
                nxt = cand[PH_W-1:0];
        end
    end

    // junction sequencing; every exit reloads the timer with the entered state's duration
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        ext_used_d = ext_used_q;
        dur        = TIME_W'(ALL_RED_S);
        if (done) begin
            case (state_q)
                GREEN: begin
                    if (sen_s_q[phase_q] && !ext_used_q && ext_q != '0) begin
                        state_d    = GREEN_EXT;
                        dur        = ext_q;
                        ext_used_d = 1'b1;
                    end else if (phase_q == '0 && !pending) begin
                        dur        = base_q;
                        ext_used_d = 1'b0;
                    end else begin
                        state_d = YELLOW;
                        dur     = yel_q;
                    end
                end
                GREEN_EXT: begin
                    state_d = YELLOW;
                    dur     = yel_q;
                end
                YELLOW: state_d = ALL_RED;
                ALL_RED: begin
                    if (walk_lat_q) begin
                        state_d = WALK;
                        dur     = walk_t_q;
                    end else begin
                        state_d    = GREEN;
                        phase_d    = nxt;
                        dur        = base_q;
                        ext_used_d = 1'b0;
                    end
                end
                default: state_d = ALL_RED;
            endcase
        end
    end

    // request latches (clear wins over set) and lamp decode of the upcoming state
    always_comb begin
        dem_d      = (dem_q | (sen_s_q & ~cur_oh)) & ~((done && state_d == GREEN) ? nxt_oh : '0);
        walk_lat_d = (done && state_d == WALK) ? 1'b0
                   : walk_lat_q | (wr_s_q & ~wr_p_q & (state_q != WALK));
        green_d    = (state_d == GREEN || state_d == GREEN_EXT) ? nxt_oh : '0;
        yellow_d   = (state_d == YELLOW) ? nxt_oh : '0;
        red_d      = ~(green_d | yellow_d);
        walk_d     = state_d == WALK;
    end

    // state, latches and registered lamp outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ALL_RED;
            phase_q    <= '0;
            ext_used_q <= 1'b0;
            dem_q      <= '0;
            walk_lat_q <= 1'b0;
            red_q      <= '1;
            yellow_q   <= '0;
            green_q    <= '0;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            ext_used_q <= ext_used_d;
            dem_q      <= dem_d;
            walk_lat_q <= walk_lat_d;
            red_q      <= red_d;
            yellow_q   <= yellow_d;
            green_q    <= green_d;
            walk_q     <= walk_d;
        end
    end

    assign red_o          = red_q;
    assign yellow_o       = yellow_q;
    assign green_o        = green_q;
    assign walk_o         = walk_q;
    assign active_phase_o = phase_q;
endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
Parametrised successor to the two-road main/side controller. Sequences NUM_PHASES approaches round-robin with demand skipping and per-phase sensor green extension. Adds a latched pedestrian walk interval, a fixed all-red clearance, and runtime-reprogrammable timing registers. It is the top-level junction FSM and drives lamp outputs directly.

Parameters:
NUM_PHASES, 4, number of approaches (2..8); phase 0 is the main road.
TIME_W, 4, width of the programmable time values, in seconds.
CLK_DIV, 100000000, clk cycles per one-second tick.
ALL_RED_S, 1, fixed all-red clearance in seconds (≥1).
PH_W, $clog2(NUM_PHASES), width of active_phase.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sensor  in  NUM_PHASES  vehicle-present per phase, asynchronous
walk_req  in  1  pedestrian button, asynchronous
reprogram  in  1  write strobe for a timing register
prog_sel  in  2  register select: 0=base green, 1=extension, 2=yellow, 3=walk
prog_value  in  TIME_W  value written
red  out  NUM_PHASES  red lamp per phase
yellow  out  NUM_PHASES  yellow lamp per phase
green  out  NUM_PHASES  green lamp per phase
walk  out  1  walk lamp
active_phase  out  PH_W  phase currently green or yellow

Behaviour:
- Clocking: one clock (clk). Reset is asynchronous and active-high (reset). sensor and walk_req pass through 2-flop synchronisers, giving 2 cycles of latency. reprogram, prog_sel and prog_value are synchronous to clk.
- Reset values:
  - State ALL_RED, red all 1, yellow and green 0, walk 0, active_phase 0.
  - Demand and walk latches 0.
  - Timing registers: base=6, ext=3, yellow=2, walk=3.
  - Reset acts immediately, with no clk edge needed.
- States: ALL_RED, GREEN, GREEN_EXT, YELLOW, WALK. Outputs are registered and decoded from state and active_phase.
  - red[p] = 1 unless p is green or yellow.
  - walk = 1 only in WALK; all reds are 1 during WALK.
- Timer:
  - On every state entry the prescaler clears and the seconds counter loads the duration D.
  - A tick fires when the prescaler reaches CLK_DIV-1. The counter decrements on each tick.
  - The state exits at the clk edge of the tick that takes the counter from 1 to 0, so dwell is exactly D*CLK_DIV cycles.
  - A programmed value of 0 is treated as 1.
- Transitions:
  - After reset, ALL_RED(ALL_RED_S) → GREEN(base) of phase 0.
  - GREEN expires: if sensor[active] is high and the extension is unused this green and ext≠0 → GREEN_EXT(ext). Otherwise, if a pending request exists → YELLOW(yellow). Otherwise, if active=0 with no other demand and no walk, reload GREEN(base) (rest in main green). If active≠0 with no requests, go to YELLOW.
  - GREEN_EXT expires → YELLOW.
  - YELLOW expires → ALL_RED(ALL_RED_S).
  - ALL_RED expires: if the walk latch is set → WALK(walk). Otherwise → GREEN of the next phase.
  - WALK expires → ALL_RED, and walk is not re-entered until a new request.
  - Extension is allowed once per green.
- Next phase: search active+1, active+2, … mod NUM_PHASES for the first set demand latch. Phase 0 always qualifies. The search wraps.
- Demand latch[p]:
  - Set when synchronised sensor[p] is high while p is not green/ext.
  - Cleared on GREEN entry of p.
  - A set and a clear in the same cycle resolve to clear.
- Walk latch:
  - Set on the rising edge of synchronised walk_req.
  - Cleared on WALK entry.
  - Edges during WALK are ignored.
- Reprogram:
  - While reprogram is high, the register selected by prog_sel takes prog_value at the edge.
  - The FSM does not restart. The new value applies at the next load of that duration; the running count is unaffected.

Decomposition:
- Package traffic_pkg holds:
  - the state enum;
  - the prog_sel encodings (SEL_BASE, SEL_EXT, SEL_YEL, SEL_WALK);
  - default time constants (6/3/2/3).
- One sub-module, tc_second_timer: prescaler plus loadable down-counter, with ports load, load_value, expired, and a tick output.

Test Plan:
All scenarios use CLK_DIV=4 and NUM_PHASES=4.
1. Reset release, no inputs → red=4'b1111 for 4 cycles, then green[0]=1 held indefinitely; other outputs 0.
2. 1-cycle pulse on sensor[2] during main green → green[0] runs to end of 24 cycles, then yellow[0] 8 cycles, all-red 4 cycles, green[2] 24 cycles with phase 1 skipped, yellow[2], all-red, back to green[0].
3. sensor[2] held high through phase 2 green → green[2] lasts 36 cycles (base+ext) exactly once, then yellow[2].
4. walk_req pulse during main green with sensor[1] pending → after yellow[0] and all-red, walk=1 with all red for 12 cycles, then all-red 4 cycles, then green[1].
5. reprogram with prog_sel=2, prog_value=5 during green → the following yellow lasts 20 cycles. A prog_value=0 write → yellow lasts 4 cycles. The green in progress is unaffected.
6. reset asserted mid-YELLOW between clk edges → red=1111, walk=0, active_phase=0 immediately. Latches and timing registers return to defaults.
